// File: rtl/alu_sys_pkg.sv
// Shared definitions for the ALU subsystem: default widths, the command
// header byte, the command-controller FSM state encoding and the ALU
// function codes understood by the system ALU.
`timescale 1ns/1ps
package alu_sys_pkg;

    // Default datapath widths and frame header.
    localparam int          DEF_DATA_WIDTH  = 8;
    localparam int          DEF_FUN_WIDTH   = 4;
    localparam logic [7:0]  DEF_CMD_HDR     = 8'hCC;
    localparam int          DEF_TIMEOUT_CYC = 255;

    // Command controller FSM states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_A    = 3'd1,
        GET_B    = 3'd2,
        GET_FUN  = 3'd3,
        ALU_RUN  = 3'd4,
        WAIT_RES = 3'd5,
        SEND     = 3'd6
    } alu_ctrl_state_e;

    // ALU function codes.
    localparam logic [3:0] ALU_FUN_ADD   = 4'h0;
    localparam logic [3:0] ALU_FUN_SUB   = 4'h1;
    localparam logic [3:0] ALU_FUN_MUL   = 4'h2;
    localparam logic [3:0] ALU_FUN_DIV   = 4'h3;
    localparam logic [3:0] ALU_FUN_AND   = 4'h4;
    localparam logic [3:0] ALU_FUN_OR    = 4'h5;
    localparam logic [3:0] ALU_FUN_NAND  = 4'h6;
    localparam logic [3:0] ALU_FUN_NOR   = 4'h7;
    localparam logic [3:0] ALU_FUN_XOR   = 4'h8;
    localparam logic [3:0] ALU_FUN_XNOR  = 4'h9;
    localparam logic [3:0] ALU_FUN_CMPEQ = 4'hA;
    localparam logic [3:0] ALU_FUN_CMPGT = 4'hB;
    localparam logic [3:0] ALU_FUN_CMPLT = 4'hC;
    localparam logic [3:0] ALU_FUN_SHR   = 4'hD;
    localparam logic [3:0] ALU_FUN_SHL   = 4'hE;

endpackage

// File: rtl/alu_cmd_timeout.sv
// Inter-byte idle counter for the command controller. Counts cycles while
// the controller waits for the next frame byte; any received byte restarts
// the count. expired_o is high for the one cycle in which the count would
// reach TIMEOUT_CYC idle cycles. Only instantiated when ALU_CTRL_TIMEOUT_EN
// is defined.
`timescale 1ns/1ps
module alu_cmd_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic run_i,      // controller is waiting for a frame byte
    input  logic clr_i,      // a byte arrived this cycle
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hit;

    // Expiry: this is the TIMEOUT_CYC-th consecutive idle cycle.
    assign hit       = run_i && !clr_i && (cnt_q == CNT_LAST);
    assign expired_o = hit;

    // Next count: restart on a byte, when not waiting, or after expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || clr_i || hit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Idle counter register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Upstream command controller for the system ALU.
// Parses 4-byte frames (header, A, B, function) from the UART RX parallel
// interface, commits operands and function to the ALU with a one-cycle
// ALU_EN pulse, captures the ALU result and hands it to UART TX.
// Optional build macro: ALU_CTRL_TIMEOUT_EN adds an inter-byte timeout that
// abandons a partially received frame.
//
// TX handshake: TX_D_VLD is high in SEND whenever TX_BUSY is low; the byte
// is considered taken in that same cycle. While TX_BUSY is high the FSM
// stays in SEND and TX_P_DATA holds its value.
`timescale 1ns/1ps
module alu_cmd_ctrl
    import alu_sys_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int                    FUN_WIDTH   = DEF_FUN_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CMD_HDR     = DEF_CMD_HDR,
    parameter int                    TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  FRAME_ERR
);

    // FSM state; readable hierarchically for checkers.
    alu_ctrl_state_e state_q;

    // Operands are staged here while a frame arrives and only reach the
    // ALU outputs once a valid function byte completes the frame, so an
    // aborted frame never disturbs the last committed operands.
    logic [DATA_WIDTH-1:0] a_stage_q;
    logic [DATA_WIDTH-1:0] b_stage_q;

    logic [DATA_WIDTH-1:0] alu_a_q;
    logic [DATA_WIDTH-1:0] alu_b_q;
    logic [FUN_WIDTH-1:0]  alu_fun_q;
    logic                  alu_en_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  frame_err_q;

    logic fun_ok;
    logic is_hdr;
    logic wait_byte;
    logic tmo_expired;

    // Function byte is legal only when the bits above the function field are clear.
    assign fun_ok    = (RX_P_DATA[DATA_WIDTH-1:FUN_WIDTH] == '0);
    assign is_hdr    = (RX_P_DATA == CMD_HDR);
    assign wait_byte = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_FUN);

`ifdef ALU_CTRL_TIMEOUT_EN
    alu_cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .CLK       (CLK),
        .RST       (RST),
        .run_i     (wait_byte),
        .clr_i     (RX_D_VLD),
        .expired_o (tmo_expired)
    );
`else
    // Without the timeout the mid-frame states wait indefinitely.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC ^ wait_byte;
    assign tmo_expired        = 1'b0;
`endif

    // Frame FSM with registered operand, enable, result and error outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            a_stage_q   <= '0;
            b_stage_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            alu_en_q    <= 1'b0;
            tx_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            alu_en_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (RX_D_VLD) begin
                        if (is_hdr) begin
                            state_q <= GET_A;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                GET_A: begin
                    // A header value here is ordinary operand data.
                    if (RX_D_VLD) begin
                        a_stage_q <= RX_P_DATA;
                        state_q   <= GET_B;
                    end else if (tmo_expired) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                GET_B: begin
                    if (RX_D_VLD) begin
                        b_stage_q <= RX_P_DATA;
                        state_q   <= GET_FUN;
                    end else if (tmo_expired) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                GET_FUN: begin
                    if (RX_D_VLD) begin
                        if (fun_ok) begin
                            alu_a_q   <= a_stage_q;
                            alu_b_q   <= b_stage_q;
                            alu_fun_q <= RX_P_DATA[FUN_WIDTH-1:0];
                            alu_en_q  <= 1'b1;
                            state_q   <= ALU_RUN;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else if (tmo_expired) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                ALU_RUN: begin
                    // ALU_EN is high for exactly this one cycle.
                    if (RX_D_VLD) begin
                        frame_err_q <= 1'b1;
                    end
                    state_q <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (RX_D_VLD) begin
                        frame_err_q <= 1'b1;
                    end
                    if (ALU_OUT_VLD) begin
                        tx_data_q <= ALU_OUT;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (RX_D_VLD) begin
                        frame_err_q <= 1'b1;
                    end
                    if (!TX_BUSY) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_FUN   = alu_fun_q;
    assign ALU_EN    = alu_en_q;
    assign TX_P_DATA = tx_data_q;
    assign FRAME_ERR = frame_err_q;
    // Strobe in the cycle TX can accept, so the result leaves three cycles
    // after the function byte when TX is idle.
    assign TX_D_VLD  = (state_q == SEND) && !TX_BUSY;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a behavioural registered ALU and a
// queue of expected TX bytes.
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;
    import alu_sys_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [7:0] ALU_OUT;
    logic       ALU_OUT_VLD;
    logic       TX_BUSY;
    logic [7:0] ALU_A;
    logic [7:0] ALU_B;
    logic [3:0] ALU_FUN;
    logic       ALU_EN;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       FRAME_ERR;

    always #5 CLK = ~CLK;

    alu_cmd_ctrl #(
        .TIMEOUT_CYC (20)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .ALU_OUT     (ALU_OUT),
        .ALU_OUT_VLD (ALU_OUT_VLD),
        .TX_BUSY     (TX_BUSY),
        .ALU_A       (ALU_A),
        .ALU_B       (ALU_B),
        .ALU_FUN     (ALU_FUN),
        .ALU_EN      (ALU_EN),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VLD    (TX_D_VLD),
        .FRAME_ERR   (FRAME_ERR)
    );

    // ---------------- counters / scoreboard ----------------
    int         check_cnt = 0;
    int         pass_cnt  = 0;
    int         cyc       = 0;
    int         tx_cnt    = 0;
    int         tx_cyc    = 0;
    int         err_cnt   = 0;
    int         en_cnt    = 0;
    int         fun_cyc   = 0;
    logic [7:0] exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] f);
        logic [15:0] p;
        case (f)
            ALU_FUN_ADD:   return a + b;
            ALU_FUN_SUB:   return a - b;
            ALU_FUN_MUL:   begin p = a * b; return p[7:0]; end
            ALU_FUN_DIV:   return (b != 0) ? a / b : 8'h00;
            ALU_FUN_AND:   return a & b;
            ALU_FUN_OR:    return a | b;
            ALU_FUN_NAND:  return ~(a & b);
            ALU_FUN_NOR:   return ~(a | b);
            ALU_FUN_XOR:   return a ^ b;
            ALU_FUN_XNOR:  return ~(a ^ b);
            ALU_FUN_CMPEQ: return (a == b) ? 8'h01 : 8'h00;
            ALU_FUN_CMPGT: return (a > b) ? 8'h01 : 8'h00;
            ALU_FUN_CMPLT: return (a < b) ? 8'h01 : 8'h00;
            ALU_FUN_SHR:   return a >> 1;
            ALU_FUN_SHL:   return a << 1;
            default:       return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        check_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    endtask

    // Registered ALU model: result and valid appear the cycle after ALU_EN.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_OUT     <= 8'h00;
            ALU_OUT_VLD <= 1'b0;
        end else begin
            ALU_OUT_VLD <= ALU_EN;
            if (ALU_EN) ALU_OUT <= alu_ref(ALU_A, ALU_B, ALU_FUN);
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RST) begin
            if (TX_D_VLD) begin
                tx_cnt++;
                tx_cyc = cyc;
                check("tx_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("tx_data", 32'(TX_P_DATA), 32'(exp_q.pop_front()));
            end
            if (FRAME_ERR) err_cnt++;
            if (ALU_EN) en_cnt++;
        end
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        fun_cyc   = cyc;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        send_byte(8'hCC);
        send_byte(a);
        send_byte(b);
        exp_q.push_back(alu_ref(a, b, f[3:0]));
        send_byte(f);
    endtask

    task automatic wait_tx(input string tag, input int budget);
        int n0;
        n0 = tx_cnt;
        for (int i = 0; i < budget && tx_cnt == n0; i++) tick();
        check(tag, 32'(tx_cnt - n0), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"},  32'(ALU_A), 32'd0);
        check({tag, "_alu_b"},  32'(ALU_B), 32'd0);
        check({tag, "_alu_fun"}, 32'(ALU_FUN), 32'd0);
        check({tag, "_alu_en"}, 32'(ALU_EN), 32'd0);
        check({tag, "_tx_data"}, 32'(TX_P_DATA), 32'd0);
        check({tag, "_tx_vld"}, 32'(TX_D_VLD), 32'd0);
        check({tag, "_frame_err"}, 32'(FRAME_ERR), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int err0;
        int en0;
        int tx0;
        int busy_fall;

        RST       = 1'b0;
        RX_P_DATA = 8'h00;
        RX_D_VLD  = 1'b0;
        TX_BUSY   = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        check("reset_state", 32'(dut.state_q), 32'(IDLE));
        RST = 1'b1;
        repeat (2) tick();

        // Nominal frame: 5 + 3.
        en0 = en_cnt;
        send_frame(8'h05, 8'h03, 8'h00);
        check("nom_alu_en", 32'(ALU_EN), 32'd1);
        check("nom_alu_a", 32'(ALU_A), 32'h05);
        check("nom_alu_b", 32'(ALU_B), 32'h03);
        check("nom_alu_fun", 32'(ALU_FUN), 32'h0);
        tick();
        check("nom_alu_en_off", 32'(ALU_EN), 32'd0);
        wait_tx("nom_tx_seen", 20);
        check("nom_latency", 32'(tx_cyc - fun_cyc), 32'd3);
        check("nom_en_pulses", 32'(en_cnt - en0), 32'd1);
        tick();

        // Bad header, then a multiply frame.
        err0 = err_cnt;
        send_byte(8'h5A);
        repeat (2) tick();
        check("badhdr_err", 32'(err_cnt - err0), 32'd1);
        err0 = err_cnt;
        send_frame(8'h0A, 8'h02, 8'h02);
        wait_tx("badhdr_tx_seen", 20);
        check("badhdr_no_err", 32'(err_cnt - err0), 32'd0);
        tick();

        // Bad function byte: error, no enable, operands untouched.
        err0 = err_cnt;
        en0  = en_cnt;
        send_byte(8'hCC);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h1F);
        repeat (3) tick();
        check("badfun_err", 32'(err_cnt - err0), 32'd1);
        check("badfun_no_en", 32'(en_cnt - en0), 32'd0);
        check("badfun_state", 32'(dut.state_q), 32'(IDLE));
        check("badfun_keep_a", 32'(ALU_A), 32'h0A);
        check("badfun_keep_b", 32'(ALU_B), 32'h02);
        check("badfun_keep_fun", 32'(ALU_FUN), 32'h2);

        // TX backpressure with a dropped byte in SEND.
        TX_BUSY = 1'b1;
        err0 = err_cnt;
        tx0  = tx_cnt;
        send_frame(8'h06, 8'h02, 8'h03);
        repeat (3) tick();
        send_byte(8'h77);
        repeat (5) tick();
        check("bp_no_tx_busy", 32'(tx_cnt - tx0), 32'd0);
        check("bp_tx_data_held", 32'(TX_P_DATA), 32'h03);
        check("bp_drop_err", 32'(err_cnt - err0), 32'd1);
        busy_fall = cyc;
        TX_BUSY = 1'b0;
        wait_tx("bp_tx_seen", 10);
        check("bp_tx_after_busy", 32'(tx_cyc >= busy_fall), 32'd1);
        tick();

        // Reset in the middle of a frame.
        send_byte(8'hCC);
        send_byte(8'h09);
        #2;
        RST = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) tick();
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        RST = 1'b1;
        tick();
        send_frame(8'h02, 8'h02, 8'h04);
        check("midrst_alu_a", 32'(ALU_A), 32'h02);
        wait_tx("midrst_tx_seen", 20);
        tick();

        // Inter-byte idle gap inside a frame.
        err0 = err_cnt;
        en0  = en_cnt;
        tx0  = tx_cnt;
        send_byte(8'hCC);
        send_byte(8'h01);
        repeat (25) tick();
`ifdef ALU_CTRL_TIMEOUT_EN
        check("tmo_err", 32'(err_cnt - err0), 32'd1);
        send_byte(8'h02);
        tick();
        send_byte(8'h03);
        repeat (3) tick();
        check("tmo_late_bytes_err", 32'(err_cnt - err0), 32'd3);
        check("tmo_no_en", 32'(en_cnt - en0), 32'd0);
        check("tmo_no_tx", 32'(tx_cnt - tx0), 32'd0);
`else
        check("gap_no_err", 32'(err_cnt - err0), 32'd0);
        send_byte(8'h02);
        exp_q.push_back(alu_ref(8'h01, 8'h02, 4'h3));
        send_byte(8'h03);
        wait_tx("gap_tx_seen", 20);
        check("gap_latency", 32'(tx_cyc - fun_cyc), 32'd3);
        check("gap_en_pulses", 32'(en_cnt - en0), 32'd1);
`endif
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
